encoder_pulse_gen: RTL

Encoder stimulus transmitter: accepts 64-bit commands on an AXI4-Stream slave and emits A/Z encoder pulse trains, one train per command. It is the transmitting counterpart of the DAQ pulse counter: its O_A/O_Z drive the DAQ I_A0/I_Z0 (or I_A1/I_Z1) inputs for in-system loopback and calibration. It keeps a cumulative pulse count so emitted totals can be checked against the DAQ's counts.

---
 rtl/encoder_pulse_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/encoder_pulse_gen.sv
// Encoder stimulus transmitter: turns 64-bit {N, PERIOD} AXI4-Stream commands into
// A/Z quadrature-index pulse trains with a cumulative A pulse count.
module encoder_pulse_gen #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int P_HIGH_CYCLES          = 1,
    parameter int P_Z_DIV                = 3
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
    input  logic                                  s00_axis_tlast,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic                                  I_EN,
    output logic                                  O_A,
    output logic                                  O_Z,
    output logic                                  O_BUSY,
    output logic                                  O_DONE,
    output logic [63:0]                           O_A_CNT
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_RUN     = 1'b1;
    localparam logic [31:0] HIGH       = 32'(P_HIGH_CYCLES);
    localparam logic [31:0] MIN_PERIOD = 32'(P_HIGH_CYCLES + 1);
    localparam int          ZW         = (P_Z_DIV > 1) ? $clog2(P_Z_DIV) : 1;
    localparam logic [ZW-1:0] Z_LAST   = ZW'(P_Z_DIV - 1);

    logic [0:0]    state;
    logic [31:0]   period_q;
    logic [31:0]   remain_q;
    logic [31:0]   phase_q;
    logic          a_d;
    logic [ZW-1:0] z_cnt;

    logic [31:0] cmd_period;
    logic [31:0] cmd_n;
    logic [31:0] cmd_p;
    logic        accept;
    logic        a_rise;

    // Strobe and last carry no meaning for a single-beat command.
    logic unused_axis;
    assign unused_axis = ^{s00_axis_tstrb, s00_axis_tlast};

    assign cmd_period = s00_axis_tdata[31:0];
    assign cmd_n      = s00_axis_tdata[63:32];
    // The period must leave at least one low cycle so every pulse has a rising edge.
    assign cmd_p      = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
    assign accept     = s00_axis_tvalid && s00_axis_tready;
    assign a_rise     = O_A && !a_d;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous and clears every register.
    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state           <= ST_IDLE;
            period_q        <= '0;
            remain_q        <= '0;
            phase_q         <= '0;
            a_d             <= 1'b0;
            z_cnt           <= '0;
            s00_axis_tready <= 1'b0;
            O_A             <= 1'b0;
            O_Z             <= 1'b0;
            O_BUSY          <= 1'b0;
            O_DONE          <= 1'b0;
            O_A_CNT         <= '0;
        end else begin
            O_DONE <= 1'b0;
            O_Z    <= 1'b0;
            a_d    <= O_A;

            // Index phase is continuous across commands; only reset clears it.
            if (a_rise) begin
                O_A_CNT <= O_A_CNT + 64'd1;
                if (z_cnt == Z_LAST) begin
                    z_cnt <= '0;
                    O_Z   <= 1'b1;
                end else begin
                    z_cnt <= z_cnt + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    s00_axis_tready <= I_EN;
                    if (accept) begin
                        if (cmd_n == 32'd0) begin
                            O_DONE <= 1'b1;
                        end else begin
                            state           <= ST_RUN;
                            period_q        <= cmd_p;
                            remain_q        <= cmd_n;
                            phase_q         <= '0;
                            O_A             <= 1'b1;
                            O_BUSY          <= 1'b1;
                            s00_axis_tready <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (phase_q == period_q - 32'd1) begin
                        phase_q  <= '0;
                        remain_q <= remain_q - 32'd1;
                        if (remain_q == 32'd1) begin
                            state           <= ST_IDLE;
                            O_A             <= 1'b0;
                            O_BUSY          <= 1'b0;
                            O_DONE          <= 1'b1;
                            s00_axis_tready <= I_EN;
                        end else begin
                            O_A <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 32'd1;
                        O_A     <= (phase_q + 32'd1) < HIGH;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
